// File: rtl/apu_mix_ctrl_if.sv
// CPU register bus for apu_mix_ctrl: register select, write/read strobes and data.
// The master drives the strobes and write data, the slave (mixer control) returns read data.
interface apu_mix_ctrl_if;
  logic [1:0] sel;
  logic       apu_wr;
  logic       cpu_rd;
  logic [7:0] din;
  logic [7:0] dout;
  logic       dout_oe;

  modport master (
    output sel,
    output apu_wr,
    output cpu_rd,
    output din,
    input  dout,
    input  dout_oe
  );

  modport slave (
    input  sel,
    input  apu_wr,
    input  cpu_rd,
    input  din,
    output dout,
    output dout_oe
  );
endinterface

// File: rtl/apu_mix_ctrl.sv
// APU mixer control: VOL/PANR/PANL/CTRL registers, power gating, divider and master volume.
// Define APU_MIX_CTRL_RAMP_EN to step the master volume toward its target on ramp_tick.
module apu_mix_ctrl #(
  parameter int NCH   = 4,
  parameter int VOL_W = 3
) (
  input  logic             apuv_4mhz,
  input  logic             apu_reset,
  apu_mix_ctrl_if.slave    bus,
  input  logic [NCH-1:0]   ch_active,
  input  logic             ramp_tick,
  output logic [NCH-1:0]   lmix,
  output logic [NCH-1:0]   rmix,
  output logic [VOL_W-1:0] lvol,
  output logic [VOL_W-1:0] rvol,
  output logic             vin_l,
  output logic             vin_r,
  output logic             ajer_2mhz,
  output logic             dyfa_1mhz,
  output logic             chan_rst,
  output logic             ramp_busy
);

  localparam logic [1:0] SEL_VOL  = 2'd0;
  localparam logic [1:0] SEL_PANR = 2'd1;
  localparam logic [1:0] SEL_PANL = 2'd2;
  localparam logic [1:0] SEL_CTRL = 2'd3;

  localparam logic [7:0] VOL_FIELD = 8'((1 << VOL_W) - 1);
  localparam logic [7:0] VOL_MASK  = 8'h88 | (VOL_FIELD << 4) | VOL_FIELD;

  logic             power_q, power_d;
  logic [7:0]       vol_q, vol_d;
  logic [7:0]       panl_q, panl_d;
  logic [7:0]       panr_q, panr_d;
  logic [1:0]       div_q, div_d;
  logic             chan_rst_q;

  // Index 0 is the right side, index 1 the left side.
  logic [VOL_W-1:0] cur_q [2];
  logic [VOL_W-1:0] cur_d [2];
  logic [VOL_W-1:0] tgt   [2];

  logic             wr_ctrl;
  logic             wr_reg;
  logic             pwr_clear;

  // Only CTRL is writable while powered down; a CTRL write with bit7 low wipes the mixer.
  assign wr_ctrl   = bus.apu_wr && (bus.sel == SEL_CTRL);
  assign wr_reg    = bus.apu_wr && power_q && (bus.sel != SEL_CTRL);
  assign pwr_clear = wr_ctrl && !bus.din[7];

  assign tgt[0] = vol_q[VOL_W-1:0];
  assign tgt[1] = vol_q[4 +: VOL_W];

  always_comb begin
    power_d = power_q;
    vol_d   = vol_q;
    panl_d  = panl_q;
    panr_d  = panr_q;
    if (wr_ctrl) begin
      power_d = bus.din[7];
    end
    if (wr_reg) begin
      case (bus.sel)
        SEL_VOL:  vol_d  = bus.din & VOL_MASK;
        SEL_PANR: panr_d = bus.din;
        SEL_PANL: panl_d = bus.din;
        default:  vol_d  = vol_q;
      endcase
    end
    if (pwr_clear) begin
      vol_d  = '0;
      panl_d = '0;
      panr_d = '0;
    end
  end

  // The divider restarts from 0 on the edge after power-on and is forced to 0 on power-off.
  assign div_d = (power_q && power_d) ? div_q + 2'd1 : 2'd0;

  for (genvar gi = 0; gi < 2; gi++) begin : g_side
`ifdef APU_MIX_CTRL_RAMP_EN
    logic [VOL_W-1:0] step;
    assign step = (cur_q[gi] < tgt[gi]) ? cur_q[gi] + VOL_W'(1) :
                  (cur_q[gi] > tgt[gi]) ? cur_q[gi] - VOL_W'(1) : cur_q[gi];
    // Stepping uses the registered target, so a write on a tick edge takes effect next tick.
    assign cur_d[gi] = pwr_clear ? '0 : (ramp_tick ? step : cur_q[gi]);
`else
    assign cur_d[gi] = pwr_clear ? '0 : tgt[gi];
`endif
  end

`ifdef APU_MIX_CTRL_RAMP_EN
  assign ramp_busy = (cur_q[0] != tgt[0]) || (cur_q[1] != tgt[1]);
`else
  logic unused_ramp_tick;
  assign unused_ramp_tick = ramp_tick;
  assign ramp_busy        = 1'b0;
`endif

  always_ff @(posedge apuv_4mhz or posedge apu_reset) begin
    if (apu_reset) begin
      power_q    <= 1'b0;
      vol_q      <= '0;
      panl_q     <= '0;
      panr_q     <= '0;
      div_q      <= '0;
      chan_rst_q <= 1'b1;
      for (int i = 0; i < 2; i++) begin
        cur_q[i] <= '0;
      end
    end else begin
      power_q    <= power_d;
      vol_q      <= vol_d;
      panl_q     <= panl_d;
      panr_q     <= panr_d;
      div_q      <= div_d;
      chan_rst_q <= !power_q;
      for (int i = 0; i < 2; i++) begin
        cur_q[i] <= cur_d[i];
      end
    end
  end

  // CTRL read image: channel status in the low bits, unused bits high, power in bit7.
  logic [7:0] ctrl_rd;
  for (genvar gi = 0; gi < 7; gi++) begin : g_ctrl_bit
    if (gi < NCH) begin : g_act
      assign ctrl_rd[gi] = ch_active[gi];
    end else begin : g_one
      assign ctrl_rd[gi] = 1'b1;
    end
  end
  assign ctrl_rd[7] = power_q;

  if (NCH > 7) begin : g_ch7
    logic unused_ch7;
    assign unused_ch7 = ch_active[7];
  end

  logic [7:0] rd_mux;
  always_comb begin
    rd_mux = 8'hFF;
    case (bus.sel)
      SEL_VOL:  rd_mux = vol_q | ~VOL_MASK;
      SEL_PANR: rd_mux = panr_q;
      SEL_PANL: rd_mux = panl_q;
      SEL_CTRL: rd_mux = ctrl_rd;
      default:  rd_mux = 8'hFF;
    endcase
  end

  assign bus.dout    = bus.cpu_rd ? rd_mux : 8'hFF;
  assign bus.dout_oe = bus.cpu_rd;

  assign lmix      = panl_q[NCH-1:0] & {NCH{power_q}};
  assign rmix      = panr_q[NCH-1:0] & {NCH{power_q}};
  assign vin_l     = vol_q[7] & power_q;
  assign vin_r     = vol_q[3] & power_q;
  assign lvol      = cur_q[1];
  assign rvol      = cur_q[0];
  assign ajer_2mhz = div_q[0];
  assign dyfa_1mhz = div_q[1];
  assign chan_rst  = chan_rst_q;

endmodule

// File: tb/tb_apu_mix_ctrl.sv
// Self-checking bench for apu_mix_ctrl: directed scenarios plus randomized traffic against
// a register-level model. Define APU_MIX_CTRL_RAMP_EN for both bench and design to test the ramp.
module tb_apu_mix_ctrl;
  localparam int NCH   = 4;
  localparam int VOL_W = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  apu_mix_ctrl_if bus_if ();

  logic [NCH-1:0]   ch_active;
  logic             ramp_tick;
  logic [NCH-1:0]   lmix, rmix;
  logic [VOL_W-1:0] lvol, rvol;
  logic             vin_l, vin_r, ajer_2mhz, dyfa_1mhz, chan_rst, ramp_busy;

  apu_mix_ctrl #(.NCH(NCH), .VOL_W(VOL_W)) dut (
    .apuv_4mhz (clk),
    .apu_reset (rst),
    .bus       (bus_if.slave),
    .ch_active (ch_active),
    .ramp_tick (ramp_tick),
    .lmix      (lmix),
    .rmix      (rmix),
    .lvol      (lvol),
    .rvol      (rvol),
    .vin_l     (vin_l),
    .vin_r     (vin_r),
    .ajer_2mhz (ajer_2mhz),
    .dyfa_1mhz (dyfa_1mhz),
    .chan_rst  (chan_rst),
    .ramp_busy (ramp_busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: register fields as plain values.
  logic       m_power, m_chan_rst, m_vin_l, m_vin_r;
  int         m_ltgt, m_rtgt, m_lcur, m_rcur, m_run;
  logic [7:0] m_panl, m_panr;

  task automatic model_reset();
    m_power = 0; m_chan_rst = 1; m_vin_l = 0; m_vin_r = 0;
    m_ltgt = 0; m_rtgt = 0; m_lcur = 0; m_rcur = 0; m_run = 0;
    m_panl = 8'h00; m_panr = 8'h00;
  endtask

  function automatic logic [7:0] exp_read(input logic [1:0] s);
    logic [7:0] r;
    r = 8'hFF;
    case (s)
      2'd0: begin
        r[7] = m_vin_l;
        r[3] = m_vin_r;
        for (int b = 0; b < VOL_W; b++) begin
          r[4+b] = m_ltgt[b];
          r[b]   = m_rtgt[b];
        end
      end
      2'd1: r = m_panr;
      2'd2: r = m_panl;
      default: begin
        r[7] = m_power;
        for (int i = 0; i < NCH && i < 7; i++) r[i] = ch_active[i];
      end
    endcase
    return r;
  endfunction

  // Advance the model by one clock using the inputs presently applied, then clock the DUT.
  task automatic tick();
    logic old_power;
    int   old_lt, old_rt;
    bit   cleared;
    old_power = m_power; old_lt = m_ltgt; old_rt = m_rtgt; cleared = 0;
    if (rst) begin
      model_reset();
    end else begin
      if (bus_if.apu_wr) begin
        if (bus_if.sel == 2'd3) begin
          m_power = bus_if.din[7];
          if (!bus_if.din[7]) begin
            m_vin_l = 0; m_vin_r = 0; m_ltgt = 0; m_rtgt = 0;
            m_panl = 8'h00; m_panr = 8'h00; cleared = 1;
          end
        end else if (old_power) begin
          case (bus_if.sel)
            2'd0: begin
              m_vin_l = bus_if.din[7];
              m_vin_r = bus_if.din[3];
              m_ltgt  = (int'(bus_if.din) >> 4) % (1 << VOL_W);
              m_rtgt  = int'(bus_if.din[2:0]) % (1 << VOL_W);
            end
            2'd1: m_panr = bus_if.din;
            default: m_panl = bus_if.din;
          endcase
        end
      end
      m_chan_rst = !old_power;
      m_run = (old_power && m_power) ? m_run + 1 : 0;
      if (cleared) begin
        m_lcur = 0; m_rcur = 0;
      end else begin
`ifdef APU_MIX_CTRL_RAMP_EN
        if (ramp_tick) begin
          if (m_lcur < old_lt) m_lcur++; else if (m_lcur > old_lt) m_lcur--;
          if (m_rcur < old_rt) m_rcur++; else if (m_rcur > old_rt) m_rcur--;
        end
`else
        m_lcur = old_lt; m_rcur = old_rt;
`endif
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [1:0] s, input logic [7:0] d);
    bus_if.apu_wr = 1'b1; bus_if.sel = s; bus_if.din = d;
    tick();
    bus_if.apu_wr = 1'b0;
  endtask

  task automatic pulse_ramp();
    ramp_tick = 1'b1;
    tick();
    ramp_tick = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ch_active = '0; bus_if.cpu_rd = 1'b1; bus_if.sel = 2'd3;
    model_reset();
    tick();
    n_checks++; if (bus_if.dout !== 8'h70) begin n_fail++; $display("FAIL rst_ctrl got=%h exp=70", bus_if.dout); end
    n_checks++; if (bus_if.dout_oe !== 1'b1) begin n_fail++; $display("FAIL rst_oe got=%b exp=1", bus_if.dout_oe); end
    n_checks++; if (lmix !== '0 || rmix !== '0) begin n_fail++; $display("FAIL rst_mix got=%b/%b exp=0/0", lmix, rmix); end
    n_checks++; if (chan_rst !== 1'b1) begin n_fail++; $display("FAIL rst_chan_rst got=%b exp=1", chan_rst); end
    n_checks++; if (ajer_2mhz !== 1'b0 || dyfa_1mhz !== 1'b0) begin n_fail++; $display("FAIL rst_div got=%b%b exp=00", dyfa_1mhz, ajer_2mhz); end
    n_checks++; if (lvol !== '0 || rvol !== '0) begin n_fail++; $display("FAIL rst_vol got=%0d/%0d exp=0/0", lvol, rvol); end
    do_write(2'd3, 8'h80);
    n_checks++; if (bus_if.dout !== 8'h70) begin n_fail++; $display("FAIL rst_wr_ignored got=%h exp=70", bus_if.dout); end
    rst = 1'b0;
    tick(); tick();
    n_checks++; if (bus_if.dout !== 8'h70 || chan_rst !== 1'b1) begin n_fail++; $display("FAIL rst_stay_off got=%h/%b exp=70/1", bus_if.dout, chan_rst); end
    $display("test_reset done");
  endtask

  task automatic test_power_on();
    int last_rise;
    logic prev_dyfa;
    do_write(2'd3, 8'h80);
    ch_active = 4'b1010; bus_if.cpu_rd = 1'b1; bus_if.sel = 2'd3;
    #1;
    n_checks++; if (bus_if.dout !== 8'hFA) begin n_fail++; $display("FAIL pwr_ctrl got=%h exp=fa", bus_if.dout); end
    n_checks++; if (chan_rst !== 1'b1) begin n_fail++; $display("FAIL pwr_chan_rst_hold got=%b exp=1", chan_rst); end
    tick();
    n_checks++; if (chan_rst !== 1'b0) begin n_fail++; $display("FAIL pwr_chan_rst_fall got=%b exp=0", chan_rst); end
    last_rise = -1; prev_dyfa = dyfa_1mhz;
    for (int k = 0; k < 12; k++) begin
      n_checks++;
      if (dyfa_1mhz !== ((m_run % 4) >= 2) || ajer_2mhz !== ((m_run % 2) == 1)) begin
        n_fail++; $display("FAIL pwr_div k=%0d got=%b%b exp_count=%0d", k, dyfa_1mhz, ajer_2mhz, m_run % 4);
      end
      if (dyfa_1mhz && !prev_dyfa) begin
        if (last_rise >= 0) begin
          n_checks++; if (k - last_rise != 4) begin n_fail++; $display("FAIL pwr_div_period got=%0d exp=4", k - last_rise); end
        end
        last_rise = k;
      end
      prev_dyfa = dyfa_1mhz;
      tick();
    end
    $display("test_power_on done");
  endtask

  task automatic test_powered_off_writes();
    do_write(2'd3, 8'h00);
    do_write(2'd2, 8'hFF);
    do_write(2'd0, 8'h77);
    bus_if.cpu_rd = 1'b1; bus_if.sel = 2'd2; #1;
    n_checks++; if (bus_if.dout !== 8'h00) begin n_fail++; $display("FAIL off_panl got=%h exp=00", bus_if.dout); end
    n_checks++; if (lmix !== '0) begin n_fail++; $display("FAIL off_lmix got=%b exp=0000", lmix); end
    bus_if.sel = 2'd0; #1;
    n_checks++; if (bus_if.dout !== 8'h00) begin n_fail++; $display("FAIL off_vol got=%h exp=00", bus_if.dout); end
    do_write(2'd3, 8'h80);
    do_write(2'd2, 8'h05);
    n_checks++; if (lmix !== 4'b0101) begin n_fail++; $display("FAIL on_lmix got=%b exp=0101", lmix); end
    bus_if.sel = 2'd2; #1;
    n_checks++; if (bus_if.dout !== 8'h05) begin n_fail++; $display("FAIL on_panl got=%h exp=05", bus_if.dout); end
    $display("test_powered_off_writes done");
  endtask

  task automatic test_volume();
    do_write(2'd3, 8'h00);
    do_write(2'd3, 8'h80);
`ifdef APU_MIX_CTRL_RAMP_EN
    do_write(2'd0, 8'h70);
    for (int k = 1; k <= 7; k++) begin
      n_checks++; if (ramp_busy !== 1'b1) begin n_fail++; $display("FAIL ramp_busy k=%0d got=%b exp=1", k, ramp_busy); end
      pulse_ramp();
      n_checks++; if (lvol !== VOL_W'(k)) begin n_fail++; $display("FAIL ramp_up k=%0d got=%0d exp=%0d", k, lvol, k); end
    end
    n_checks++; if (ramp_busy !== 1'b0) begin n_fail++; $display("FAIL ramp_done got=%b exp=0", ramp_busy); end
    tick();
    n_checks++; if (lvol !== 3'd7) begin n_fail++; $display("FAIL ramp_no_tick got=%0d exp=7", lvol); end
    do_write(2'd3, 8'h00);
    do_write(2'd3, 8'h80);
    do_write(2'd0, 8'h70);
    for (int k = 0; k < 5; k++) pulse_ramp();
    n_checks++; if (lvol !== 3'd5) begin n_fail++; $display("FAIL ramp_mid got=%0d exp=5", lvol); end
    do_write(2'd0, 8'h30);
    pulse_ramp();
    n_checks++; if (lvol !== 3'd4) begin n_fail++; $display("FAIL ramp_down1 got=%0d exp=4", lvol); end
    pulse_ramp();
    n_checks++; if (lvol !== 3'd3 || ramp_busy !== 1'b0) begin n_fail++; $display("FAIL ramp_down2 got=%0d/%b exp=3/0", lvol, ramp_busy); end
    ramp_tick = 1'b1;
    do_write(2'd0, 8'h07);
    ramp_tick = 1'b0;
    n_checks++; if (lvol !== 3'd3 || rvol !== 3'd0) begin n_fail++; $display("FAIL ramp_coincident got=%0d/%0d exp=3/0", lvol, rvol); end
    pulse_ramp();
    n_checks++; if (lvol !== 3'd2 || rvol !== 3'd1) begin n_fail++; $display("FAIL ramp_new_tgt got=%0d/%0d exp=2/1", lvol, rvol); end
`else
    do_write(2'd0, 8'h77);
    n_checks++; if (ramp_busy !== 1'b0) begin n_fail++; $display("FAIL vol_busy0 got=%b exp=0", ramp_busy); end
    tick();
    n_checks++; if (lvol !== 3'd7 || rvol !== 3'd7) begin n_fail++; $display("FAIL vol_load got=%0d/%0d exp=7/7", lvol, rvol); end
    n_checks++; if (ramp_busy !== 1'b0) begin n_fail++; $display("FAIL vol_busy1 got=%b exp=0", ramp_busy); end
    pulse_ramp();
    n_checks++; if (lvol !== 3'd7 || rvol !== 3'd7) begin n_fail++; $display("FAIL vol_tick_ignored got=%0d/%0d exp=7/7", lvol, rvol); end
`endif
    $display("test_volume done");
  endtask

  task automatic test_power_off_mid_ramp();
    do_write(2'd0, 8'h77);
    pulse_ramp();
`ifdef APU_MIX_CTRL_RAMP_EN
    n_checks++; if (ramp_busy !== 1'b1) begin n_fail++; $display("FAIL midramp_busy got=%b exp=1", ramp_busy); end
`endif
    do_write(2'd3, 8'h00);
    n_checks++; if (lvol !== '0 || rvol !== '0) begin n_fail++; $display("FAIL off_snap got=%0d/%0d exp=0/0", lvol, rvol); end
    bus_if.cpu_rd = 1'b1; bus_if.sel = 2'd0; #1;
    n_checks++; if (bus_if.dout !== 8'h00) begin n_fail++; $display("FAIL off_vol_clr got=%h exp=00", bus_if.dout); end
    n_checks++; if (ramp_busy !== 1'b0) begin n_fail++; $display("FAIL off_busy got=%b exp=0", ramp_busy); end
    $display("test_power_off_mid_ramp done");
  endtask

  task automatic test_random();
    logic [VOL_W-1:0] e_lvol, e_rvol;
    logic             e_busy;
    do_write(2'd3, 8'h80);
    for (int c = 0; c < 600; c++) begin
      ch_active     = NCH'($urandom);
      bus_if.sel    = 2'($urandom_range(0, 3));
      bus_if.apu_wr = ($urandom_range(0, 2) == 0);
      bus_if.din    = 8'($urandom);
      if (bus_if.sel == 2'd3) bus_if.din[7] = ($urandom_range(0, 9) != 0);
      bus_if.cpu_rd = 1'($urandom_range(0, 1));
      ramp_tick     = ($urandom_range(0, 2) == 0);
      #1;
      if (bus_if.cpu_rd) begin
        n_checks++; if (bus_if.dout !== exp_read(bus_if.sel)) begin n_fail++; $display("FAIL rnd_dout c=%0d sel=%0d got=%h exp=%h", c, bus_if.sel, bus_if.dout, exp_read(bus_if.sel)); end
      end
      n_checks++; if (bus_if.dout_oe !== bus_if.cpu_rd) begin n_fail++; $display("FAIL rnd_oe c=%0d got=%b exp=%b", c, bus_if.dout_oe, bus_if.cpu_rd); end
      tick();
      e_lvol = VOL_W'(m_lcur); e_rvol = VOL_W'(m_rcur);
`ifdef APU_MIX_CTRL_RAMP_EN
      e_busy = (m_lcur != m_ltgt) || (m_rcur != m_rtgt);
`else
      e_busy = 1'b0;
`endif
      n_checks++; if (lmix !== (m_panl[NCH-1:0] & {NCH{m_power}}) || rmix !== (m_panr[NCH-1:0] & {NCH{m_power}})) begin
        n_fail++; $display("FAIL rnd_mix c=%0d got=%b/%b exp=%b/%b", c, lmix, rmix, m_panl[NCH-1:0] & {NCH{m_power}}, m_panr[NCH-1:0] & {NCH{m_power}});
      end
      n_checks++; if (lvol !== e_lvol || rvol !== e_rvol) begin n_fail++; $display("FAIL rnd_vol c=%0d got=%0d/%0d exp=%0d/%0d", c, lvol, rvol, e_lvol, e_rvol); end
      n_checks++; if (ramp_busy !== e_busy) begin n_fail++; $display("FAIL rnd_busy c=%0d got=%b exp=%b", c, ramp_busy, e_busy); end
      n_checks++; if (vin_l !== (m_vin_l & m_power) || vin_r !== (m_vin_r & m_power)) begin n_fail++; $display("FAIL rnd_vin c=%0d got=%b%b exp=%b%b", c, vin_l, vin_r, m_vin_l & m_power, m_vin_r & m_power); end
      n_checks++; if (chan_rst !== m_chan_rst) begin n_fail++; $display("FAIL rnd_chan_rst c=%0d got=%b exp=%b", c, chan_rst, m_chan_rst); end
      n_checks++; if (ajer_2mhz !== ((m_run % 2) == 1) || dyfa_1mhz !== ((m_run % 4) >= 2)) begin n_fail++; $display("FAIL rnd_div c=%0d got=%b%b exp_count=%0d", c, dyfa_1mhz, ajer_2mhz, m_run % 4); end
    end
    bus_if.apu_wr = 1'b0; ramp_tick = 1'b0;
    $display("test_random done");
  endtask

  task automatic test_async_reset();
    do_write(2'd3, 8'h80);
    do_write(2'd2, 8'h0F);
    do_write(2'd1, 8'h0F);
    do_write(2'd0, 8'h77);
    pulse_ramp(); tick();
    ch_active = '0; bus_if.cpu_rd = 1'b1; bus_if.sel = 2'd3;
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (bus_if.dout !== 8'h70) begin n_fail++; $display("FAIL async_ctrl got=%h exp=70", bus_if.dout); end
    n_checks++; if (lmix !== '0 || rmix !== '0) begin n_fail++; $display("FAIL async_mix got=%b/%b exp=0/0", lmix, rmix); end
    n_checks++; if (chan_rst !== 1'b1 || lvol !== '0 || rvol !== '0) begin n_fail++; $display("FAIL async_state got=%b/%0d/%0d exp=1/0/0", chan_rst, lvol, rvol); end
    n_checks++; if (ajer_2mhz !== 1'b0 || dyfa_1mhz !== 1'b0 || vin_l !== 1'b0) begin n_fail++; $display("FAIL async_div got=%b%b/%b exp=00/0", dyfa_1mhz, ajer_2mhz, vin_l); end
    model_reset();
    tick();
    rst = 1'b0;
    tick();
    bus_if.sel = 2'd2; #1;
    n_checks++; if (bus_if.dout !== 8'h00 || chan_rst !== 1'b1) begin n_fail++; $display("FAIL async_after got=%h/%b exp=00/1", bus_if.dout, chan_rst); end
    $display("test_async_reset done");
  endtask

  initial begin
    rst = 1'b1; ch_active = '0; ramp_tick = 1'b0;
    bus_if.sel = 2'd0; bus_if.apu_wr = 1'b0; bus_if.cpu_rd = 1'b0; bus_if.din = 8'h00;
    test_reset();
    test_power_on();
    test_powered_off_writes();
    test_volume();
    test_power_off_mid_ramp();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
